// File: rtl/hpm_counter_bank.sv
// Hardware performance monitor: mcycle, minstret and NumCounters event-selectable 64-bit counters.
// Optional registered wrap pulses on overflow_o are enabled by defining HPM_OVERFLOW_EN.

module hpm_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] cnt_o
);
    logic [63:0] cnt_q, cnt_d;

    // A write to either half drops this cycle's increment entirely.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) cnt_d[31:0]  = wdata_i[31:0];
            if (wr_hi_i) cnt_d[63:32] = wdata_i[63:32];
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

module hpm_counter_bank #(
    parameter int DataWidth   = 32,
    parameter int NumCounters = 4,
    parameter int NumEvents   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumEvents-1:0]   events_i,
    input  logic                   retire_i,
    input  logic                   wen_i,
    input  logic [11:0]            waddr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [11:0]            raddr_i,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   hit_o,
    output logic [NumCounters+1:0] overflow_o
);
    localparam int NC   = NumCounters + 2;
    localparam int SelW = $clog2(NumEvents + 1);

    generate
        if (DataWidth != 32 && DataWidth != 64) begin : g_bad_xlen
            $fatal(1, "hpm_counter_bank: DataWidth must be 32 or 64");
        end
        if (NumCounters < 1 || NumCounters > 29) begin : g_bad_cnt
            $fatal(1, "hpm_counter_bank: NumCounters must be 1..29");
        end
        if (NumEvents < 1 || NumEvents > 63) begin : g_bad_evt
            $fatal(1, "hpm_counter_bank: NumEvents must be 1..63");
        end
    endgenerate

    // Counter index j: 0 = mcycle, 1 = minstret, 2+i = mhpmcounter(3+i).
    function automatic logic [11:0] cnt_addr(input int j);
        if (j == 0) return 12'hB00;
        if (j == 1) return 12'hB02;
        return 12'(32'hB01 + j);
    endfunction

    function automatic int inh_bit(input int j);
        if (j == 0) return 0;
        if (j == 1) return 2;
        return j + 1;
    endfunction

    logic [NumCounters-1:0][SelW-1:0] sel_q, sel_d;
    logic [NC-1:0]                    inh_q, inh_d;
    logic [NC-1:0][63:0]              cnt;
    logic [NC-1:0]                    inc, wr_lo, wr_hi;
    logic [(1<<SelW)-1:0]             ev_ext;
    logic [63:0]                      wdata64;

    generate
        if (DataWidth == 64) begin : g_w64
            assign wdata64 = wdata_i[63:0];
        end else begin : g_w32
            assign wdata64 = {wdata_i[31:0], wdata_i[31:0]};
        end
    endgenerate

    // Slot 0 is the "never counts" selection; unused upper slots stay 0.
    always_comb begin
        ev_ext = '0;
        ev_ext[NumEvents:1] = events_i;
    end

    always_comb begin
        for (int j = 0; j < NC; j++) begin
            wr_lo[j] = wen_i && (waddr_i == cnt_addr(j));
            wr_hi[j] = (DataWidth == 32) ? (wen_i && (waddr_i == cnt_addr(j) + 12'h080))
                                         : wr_lo[j];
        end
    end

    always_comb begin
        inc[0] = ~inh_q[0];
        inc[1] = retire_i & ~inh_q[1];
        for (int i = 0; i < NumCounters; i++)
            inc[i+2] = ev_ext[sel_q[i]] & ~inh_q[i+2];
    end

    generate
        for (genvar j = 0; j < NC; j++) begin : g_cnt
            hpm_counter u_cnt (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .inc_i   (inc[j]),
                .wr_lo_i (wr_lo[j]),
                .wr_hi_i (wr_hi[j]),
                .wdata_i (wdata64),
                .cnt_o   (cnt[j])
            );
        end
    endgenerate

    // Out-of-range event selections are stored as 0 (WARL).
    always_comb begin
        sel_d = sel_q;
        inh_d = inh_q;
        for (int i = 0; i < NumCounters; i++) begin
            if (wen_i && (waddr_i == 12'(32'h323 + i)))
                sel_d[i] = (wdata_i > DataWidth'(NumEvents)) ? '0 : wdata_i[SelW-1:0];
        end
        if (wen_i && (waddr_i == 12'h320)) begin
            for (int j = 0; j < NC; j++)
                inh_d[j] = wdata_i[inh_bit(j)];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q <= '0;
            inh_q <= '0;
        end else begin
            sel_q <= sel_d;
            inh_q <= inh_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        hit_o   = 1'b0;
        for (int j = 0; j < NC; j++) begin
            if (raddr_i == cnt_addr(j)) begin
                rdata_o = cnt[j][DataWidth-1:0];
                hit_o   = 1'b1;
            end
            if (DataWidth == 32 && raddr_i == cnt_addr(j) + 12'h080) begin
                rdata_o = DataWidth'(cnt[j][63:32]);
                hit_o   = 1'b1;
            end
        end
        for (int i = 0; i < NumCounters; i++) begin
            if (raddr_i == 12'(32'h323 + i)) begin
                rdata_o = DataWidth'(sel_q[i]);
                hit_o   = 1'b1;
            end
        end
        if (raddr_i == 12'h320) begin
            for (int j = 0; j < NC; j++)
                rdata_o[inh_bit(j)] = inh_q[j];
            hit_o = 1'b1;
        end
    end

`ifdef HPM_OVERFLOW_EN
    logic [NC-1:0] ovf_q, ovf_d;

    // Only an increment from all-ones wraps; writes never pulse.
    always_comb begin
        for (int j = 0; j < NC; j++)
            ovf_d[j] = inc[j] & ~(wr_lo[j] | wr_hi[j]) & (&cnt[j]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ovf_q <= '0;
        else       ovf_q <= ovf_d;
    end

    assign overflow_o = ovf_q;
`else
    assign overflow_o = '0;
`endif

endmodule

// File: doc/hpm_counter_bank.md
# hpm_counter_bank

Parametrised hardware performance monitor for the SCHOLAR RISC-V core. It replaces the fixed `mcycle`/`mhpmcounter3`/`mhpmcounter4` wiring with `mcycle`, `minstret` and `NumCounters` event-selectable counters. Each counter can be individually inhibited and has optional wrap detection. It sits beside the CSR file: decode reads it through the CSR read port, and writeback writes it through the CSR write port.

## Interface
- `DataWidth`, default 32: XLEN, either 32 or 64; any other value is a fatal elaboration error.
- `NumCounters`, default 4: number of `mhpmcounter3+i` counters, range 1..29.
- `NumEvents`, default 8: width of `events_i`, range 1..63.
- `clk_i` input, 1 bit: system clock.
- `rst_i` input, 1 bit: reset, asynchronous, active-high.
- `events_i` input, `NumEvents` bits: single-cycle event strobes, for example dirty stall and softreset flush.
- `retire_i` input, 1 bit: an instruction retires this cycle (writeback valid).
- `wen_i` input, 1 bit: CSR write enable.
- `waddr_i` input, 12 bits: CSR write address.
- `wdata_i` input, `DataWidth` bits: CSR write data.
- `raddr_i` input, 12 bits: CSR read address.
- `rdata_o` output, `DataWidth` bits: CSR read data (combinational).
- `hit_o` output, 1 bit: `raddr_i` is mapped by this block (combinational).
- `overflow_o` output, `NumCounters+2` bits: wrap pulse per counter. Bit 0 is `mcycle`, bit 1 is `minstret`, bit 2+i is hpm i.

## Operation
- All counters are 64 bits wide regardless of `DataWidth`.
- **CSR map:**
  - `mcycle` 0xB00, `minstret` 0xB02, `mhpmcounter(3+i)` 0xB03+i.
  - When `DataWidth==32`, high halves are at 0xB80, 0xB82 and 0xB83+i.
  - `mhpmevent(3+i)` 0x323+i; `mcountinhibit` 0x320.
- **Event selection:** `mhpmevent` holds `sel`.
  - `sel=0` means the counter never counts.
  - `sel=k` with 1≤k≤`NumEvents` counts `events_i[k-1]`.
  - Writes with a value greater than `NumEvents` store 0 (WARL).
- **`mcountinhibit`:**
  - Bit 0 inhibits `mcycle`, bit 2 inhibits `minstret`, bit 3+i inhibits hpm i.
  - Bit 1 and bits above 2+`NumCounters` are hardwired 0, ignore writes and read 0.
- **Increment conditions:**
  - `mcycle` +1 every cycle.
  - `minstret` +1 when `retire_i`.
  - hpm i +1 when the selected event is high.
  - Every increment is suppressed while the counter's inhibit bit is set.
- **Write priority:** a CSR write to a counter, or to either half of it, wins over that counter's increment in the same cycle; the increment is dropped.
  - RV32 half write replaces only the addressed 32 bits; the other half is held.
  - RV64 write replaces all 64 bits.
- **Wrap:** a counter at all-ones that increments becomes 0.
- **Unmapped addresses:** reads return 0 with `hit_o=0`. Writes to unmapped addresses, or to `mhpmevent`/`mcountinhibit` indices at or above `NumCounters`, are ignored.
- **Read values:** `rdata_o` shows registered values, i.e. state before this cycle's increment or write.
- **RV64 reads:** the 0xB8x addresses are unmapped.

## Timing
- **Reset:** on `rst_i`, asynchronously, all counters, `mhpmevent` and `mcountinhibit` become 0 and `overflow_o` becomes 0. `rdata_o` then reads 0 for every address.
- **Reset mid-count:** reset asserted mid-count clears state immediately. The first increment occurs on the first rising edge after `rst_i` deasserts.
- **Write visibility:** a write at edge N is visible on `rdata_o` in cycle N+1.
- **Event latency:** an event sampled high at edge N is visible in the counter from cycle N+1.
- **Inhibit latency:** a write to `mcountinhibit` at edge N affects increments from edge N+1 onward. The increment at edge N uses the old inhibit value.
- **Simultaneous write and event:** a write to `mhpmevent` and a matching event in the same cycle are resolved with the old `sel`.

## Configuration
- Macro `HPM_OVERFLOW_EN`, defined:
  - `overflow_o[j]` is a registered one-cycle pulse, high in the cycle after counter j wraps from all-ones to 0 by increment.
  - A write of 0 does not generate a pulse.
- Macro `HPM_OVERFLOW_EN`, undefined:
  - The port remains present and is tied to 0.
  - Counters still wrap silently.

## Test plan
- **Reset and idle count:** assert `rst_i` for 3 cycles, then release and run 10 cycles with no events.
  - `mcycle` reads 10; `minstret` and all hpm counters read 0.
  - `hit_o=0` for address 0x7C0.
- **Event selection and WARL:** write `mhpmevent3`=2, pulse `events_i[1]` 5 times and `events_i[0]` 7 times.
  - `mhpmcounter3` reads 5.
  - Writing `mhpmevent3`=`NumEvents`+1 reads back 0.
- **Inhibit:** set `mcountinhibit`=0x5 with `retire_i` high for 8 cycles.
  - `mcycle` and `minstret` are frozen.
  - Clearing the register resumes counting one edge later.
  - Writing bit 1 reads back 0.
- **Write-vs-increment collision (RV32):** write 0xFFFF_FFFF to 0xB03 in a cycle where its event is high.
  - The low half reads 0xFFFF_FFFF and the high half is unchanged.
  - The next event makes the counter 0x1_0000_0000.
- **Overflow (`HPM_OVERFLOW_EN`):** preload `mcycle` to all-ones.
  - After one edge `mcycle`=0, and `overflow_o[0]` is high for exactly one cycle.
  - Without the macro, `overflow_o` stays 0.
